pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the 32-bit MIPS core.
- Drives the current PC into the incrementer (`pcin`) and consumes its result (`pcout`, PC+4) as the sequential next-PC.
- Issues single-outstanding requests to instruction memory and hands each fetched word, with its PC, to the decode stage through a one-entry valid/ready buffer.
- Accepts branch/jump redirects from downstream.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_out  output  32  current PC register; connects to incrementer `pcin`.
- incr_out  input  32  incrementer `pcout` (pc_out+4, combinational).
- imem_req  output  1  instruction-memory request.
- imem_addr  output  32  request address; stable while imem_req=1 and no ack.
- imem_ack  input  1  one-cycle response strobe; imem_rdata valid the same cycle.
- imem_rdata  input  32  instruction word.
- redirect_valid  input  1  one-cycle branch/jump redirect.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
- id_valid  output  1  decode buffer holds a valid instruction.
- id_ready  input  1  decode stage accepts the buffer this cycle.
- id_instr  output  32  buffered instruction.
- id_pc  output  32  PC of the buffered instruction.
- id_pc_plus4  output  32  PC+4 of the buffered instruction.

Behaviour:
- Reset (asynchronous, any time, including mid-request):
  - pc = RESET_PC; state = IDLE.
  - imem_req = 0; imem_addr = 0; kill = 0.
  - id_valid = 0; id_instr = id_pc = id_pc_plus4 = 0.
  - Any in-flight memory response arriving after reset is ignored.
- States: IDLE, FETCH, WAIT.
- IDLE:
  - Next edge goes to FETCH with imem_addr <= pc.
  - If redirect_valid, pc <= redirect_pc first, and imem_addr takes the redirected value.
- FETCH:
  - imem_req = 1; imem_addr held until imem_ack.
  - id_valid = 0 throughout FETCH (buffer is always empty here).
- FETCH, imem_ack=1, kill=0, no redirect:
  - id_instr <= imem_rdata; id_pc <= pc; id_pc_plus4 <= incr_out.
  - id_valid <= 1; pc <= incr_out; go to WAIT.
- FETCH, redirect_valid=1, no ack:
  - pc <= redirect_pc; kill <= 1; imem_addr unchanged (request must complete).
- FETCH, imem_ack=1 with kill=1:
  - Discard rdata; kill <= 0; imem_addr <= pc; remain in FETCH.
- FETCH, imem_ack=1 and redirect_valid=1 in the same cycle:
  - Discard rdata; pc <= redirect_pc; imem_addr <= redirect_pc; kill <= 0; remain in FETCH.
- WAIT:
  - imem_req = 0; id_valid = 1; id_* outputs held stable.
  - id_ready=1: id_valid <= 0; go to FETCH with imem_addr <= pc (one request issued per consumed instruction).
  - redirect_valid=1 (with or without id_ready): flush, id_valid <= 0; pc <= redirect_pc; imem_addr <= redirect_pc; go to FETCH.
- Priority: rst > redirect_valid > imem_ack > id_ready.
- Arithmetic and wrap-around:
  - PC arithmetic is done only by the incrementer, modulo 2^32.
  - pc = 32'hFFFF_FFFC advances to 32'h0000_0000 with no special handling.
- imem_ack seen outside FETCH: ignored.
- Latency:
  - First imem_req one cycle after rst deasserts.
  - id_valid rises the cycle after an accepted ack.
  - Back-to-back throughput: one instruction per (memory latency + 2) cycles.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: rst pulse; memory acks 2 cycles after req; id_ready=1 always.
  - Required: imem_addr sequence 0x0, 0x4, 0x8; id_pc/id_pc_plus4 pairs (0x0,0x4), (0x4,0x8); pc_out == imem_addr during each request.
- Decode stall:
  - Stimulus: id_ready=0 for 5 cycles while the instruction at 0x4 is buffered.
  - Required: id_valid stays 1; id_instr/id_pc (0x4) stable; imem_req=0; fetch of 0x8 starts the cycle after id_ready=1.
- Redirect during outstanding request:
  - Stimulus: redirect_valid with redirect_pc=0x100 while a request to 0x8 awaits ack.
  - Required: imem_addr stays 0x8 until ack; that rdata is never presented (id_valid stays 0); next request addresses 0x100; id_pc=0x100.
- Redirect coincident with ack, and in WAIT with id_ready=1:
  - Stimulus: redirect_pc=0x200 on the ack cycle; separately redirect_pc=0x300 with id_ready=1 while the buffer holds 0x10.
  - Required: no instruction from the acked/flushed fetch reaches decode; next imem_addr is 0x200 and 0x300 respectively.
- Wrap-around:
  - Stimulus: redirect_pc=0xFFFF_FFFC.
  - Required: id_pc=0xFFFF_FFFC, id_pc_plus4=0x0; next imem_addr=0x0.
  - Stimulus: redirect_pc=0x103.
  - Required: imem_addr=0x100.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously while in WAIT and while in FETCH with kill=1.
  - Required: outputs reach reset values immediately (before the next edge); a late ack after reset is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Keeps one memory request outstanding at a time. Each fetched word, with its
// PC and PC+4, is handed to decode through a one-entry valid/ready buffer.
// A redirect that arrives while a request is still in flight sets kill: the
// request still has to finish, and the word it returns is dropped.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] incr_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_imem_addr;
    logic        r_imem_req;
    logic        r_kill;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;

    // Redirect targets are word-aligned; the two low bits are dropped.
    logic [31:0] w_redirect_pc;
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

    // Fetch sequencer: PC, request and decode-buffer registers in one FSM.
    // Order of precedence: reset, then redirect, then ack, then id_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_imem_addr   <= 32'h0000_0000;
            r_imem_req    <= 1'b0;
            r_kill        <= 1'b0;
            r_id_valid    <= 1'b0;
            r_id_instr    <= 32'h0000_0000;
            r_id_pc       <= 32'h0000_0000;
            r_id_pc_plus4 <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                    if (redirect_valid) begin
                        r_pc        <= w_redirect_pc;
                        r_imem_addr <= w_redirect_pc;
                    end else begin
                        r_imem_addr <= r_pc;
                    end
                end
                S_FETCH: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirect_pc;
                        if (imem_ack) begin
                            // The request completes now, so the new target
                            // can be issued without a kill.
                            r_imem_addr <= w_redirect_pc;
                            r_kill      <= 1'b0;
                        end else begin
                            // The address stays put until the request
                            // completes; its data is dropped on return.
                            r_kill <= 1'b1;
                        end
                    end else if (imem_ack) begin
                        if (r_kill) begin
                            r_kill      <= 1'b0;
                            r_imem_addr <= r_pc;
                        end else begin
                            r_id_instr    <= imem_rdata;
                            r_id_pc       <= r_pc;
                            r_id_pc_plus4 <= incr_out;
                            r_id_valid    <= 1'b1;
                            r_pc          <= incr_out;
                            r_imem_req    <= 1'b0;
                            r_state       <= S_WAIT;
                        end
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_id_valid  <= 1'b0;
                        r_pc        <= w_redirect_pc;
                        r_imem_addr <= w_redirect_pc;
                        r_imem_req  <= 1'b1;
                        r_state     <= S_FETCH;
                    end else if (id_ready) begin
                        r_id_valid  <= 1'b0;
                        r_imem_addr <= r_pc;
                        r_imem_req  <= 1'b1;
                        r_state     <= S_FETCH;
                    end else begin
                        r_id_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                    r_id_valid <= 1'b0;
                    r_kill     <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out      = r_pc;
    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: memory model with a fixed two-cycle ack,
// an address scoreboard checked when each request starts, a decode
// scoreboard checked at each consumed handshake, plus directed sequences.
module tb_pc_fetch_unit;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] incr_out;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_id_q[$];
    logic        late_ack_req;

    typedef struct {
        logic [31:0] redir_in;
        logic [31:0] buf_pc;
        logic [31:0] exp_addr;
    } redir_vec_t;

    redir_vec_t vecs[4];

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .incr_out(incr_out),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
    );

    // The incrementer: PC+4, wrapping modulo 2^32.
    assign incr_out = pc_out + 32'd4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string what);
        int n;
        n = 0;
        while (!id_valid && n < 40) begin
            tick();
            n++;
        end
        check({"wait_valid_", what}, {31'd0, id_valid}, 32'd1);
    endtask

    task automatic consume(input string what);
        wait_valid(what);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
    endtask

    // Memory model: acks LAT cycles into a request, checks the request
    // address against the expected queue and its stability while pending.
    initial begin
        int          cnt;
        logic [31:0] hold;
        cnt        = 0;
        hold       = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_ack) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end
            if (late_ack_req && !imem_req) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hBAD0_BAD0;
            end else if (imem_req) begin
                if (cnt == 0) begin
                    if (exp_addr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL req_unexpected: got addr %h, none expected", imem_addr);
                    end else begin
                        check("req_addr", imem_addr, exp_addr_q.pop_front());
                    end
                    hold = imem_addr;
                end else begin
                    check("req_addr_stable", imem_addr, hold);
                end
                cnt++;
                if (cnt == LAT) begin
                    imem_ack   = 1'b1;
                    imem_rdata = instr_of(imem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Decode monitor: every consumed instruction must match the next expected PC.
    initial begin
        logic [31:0] p;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("req_and_valid_exclusive", {31'd0, id_valid & imem_req}, 32'd0);
                if (id_valid && id_ready && !redirect_valid) begin
                    if (exp_id_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL id_unexpected: got pc %h, none expected", id_pc);
                    end else begin
                        p = exp_id_q.pop_front();
                        check("id_pc", id_pc, p);
                        check("id_pc_plus4", id_pc_plus4, p + 32'd4);
                        check("id_instr", id_instr, instr_of(p));
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc_out"}, pc_out, 32'h0);
        check({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_imem_addr"}, imem_addr, 32'h0);
        check({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, "_id_instr"}, id_instr, 32'h0);
        check({tag, "_id_pc"}, id_pc, 32'h0);
        check({tag, "_id_pc_plus4"}, id_pc_plus4, 32'h0);
    endtask

    initial begin
        vecs[0] = '{redir_in: 32'h0000_0010, buf_pc: 32'h0000_0200, exp_addr: 32'h0000_0010};
        vecs[1] = '{redir_in: 32'h0000_0300, buf_pc: 32'h0000_0010, exp_addr: 32'h0000_0300};
        vecs[2] = '{redir_in: 32'h0000_0103, buf_pc: 32'h0000_0300, exp_addr: 32'h0000_0100};
        vecs[3] = '{redir_in: 32'hFFFF_FFFC, buf_pc: 32'h0000_0100, exp_addr: 32'hFFFF_FFFC};

        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        late_ack_req   = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Sequential fetch from RESET_PC.
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_id_q.push_back(32'h0);
        exp_id_q.push_back(32'h4);
        rst = 1'b0;
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_req_pc_match", pc_out, imem_addr);
        consume("pc0");
        check("req4_pc_match", pc_out, imem_addr);

        // Decode stall with 0x4 buffered.
        wait_valid("pc4");
        for (int i = 0; i < 5; i++) begin
            check("stall_id_valid", {31'd0, id_valid}, 32'd1);
            check("stall_id_pc", id_pc, 32'h4);
            check("stall_id_pc_plus4", id_pc_plus4, 32'h8);
            check("stall_id_instr", id_instr, instr_of(32'h4));
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("after_stall_req", {31'd0, imem_req}, 32'd1);
        check("after_stall_addr", imem_addr, 32'h8);
        check("after_stall_pc_match", pc_out, imem_addr);

        // Redirect to 0x100 while the 0x8 request is pending.
        exp_addr_q.push_back(32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("kill_addr_held", imem_addr, 32'h8);
        check("kill_ack_seen", {31'd0, imem_ack}, 32'd1);
        check("kill_no_valid", {31'd0, id_valid}, 32'd0);
        tick();
        check("kill_next_addr", imem_addr, 32'h100);
        check("kill_next_req", {31'd0, imem_req}, 32'd1);
        check("kill_no_valid2", {31'd0, id_valid}, 32'd0);
        exp_id_q.push_back(32'h100);
        exp_addr_q.push_back(32'h104);
        consume("pc100");

        // Redirect to 0x200 on the ack cycle of the 0x104 request.
        tick();
        check("coinc_ack_seen", {31'd0, imem_ack}, 32'd1);
        exp_addr_q.push_back(32'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("coinc_addr", imem_addr, 32'h200);
        check("coinc_req", {31'd0, imem_req}, 32'd1);
        check("coinc_no_valid", {31'd0, id_valid}, 32'd0);

        // Redirects while the buffer holds an instruction (id_ready also high).
        for (int i = 0; i < 4; i++) begin
            wait_valid("vec");
            check("vec_buf_pc", id_pc, vecs[i].buf_pc);
            check("vec_buf_pc_plus4", id_pc_plus4, vecs[i].buf_pc + 32'd4);
            check("vec_buf_instr", id_instr, instr_of(vecs[i].buf_pc));
            exp_addr_q.push_back(vecs[i].exp_addr);
            redirect_valid = 1'b1;
            redirect_pc    = vecs[i].redir_in;
            id_ready       = 1'b1;
            tick();
            redirect_valid = 1'b0;
            id_ready       = 1'b0;
            check("vec_req", {31'd0, imem_req}, 32'd1);
            check("vec_addr", imem_addr, vecs[i].exp_addr);
            check("vec_flushed", {31'd0, id_valid}, 32'd0);
        end

        // Wrap-around at the top of the address space.
        wait_valid("wrap");
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_id_pc_plus4", id_pc_plus4, 32'h0);
        exp_id_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        consume("wrap");
        check("wrap_next_addr", imem_addr, 32'h0);
        check("wrap_next_pc", pc_out, 32'h0);

        // Asynchronous reset while in WAIT.
        wait_valid("pre_reset");
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_wait");
        tick();
        exp_addr_q.push_back(32'h0);
        rst = 1'b0;
        tick();
        check("restart_req", {31'd0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, 32'h0);

        // Asynchronous reset while in FETCH with a kill pending, then a late ack.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        tick();
        redirect_valid = 1'b0;
        check("kill_pending_pc", pc_out, 32'h400);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_fetch");
        late_ack_req = 1'b1;
        tick();
        check("late_ack_driven", {31'd0, imem_ack}, 32'd1);
        late_ack_req = 1'b0;
        exp_addr_q.push_back(32'h0);
        exp_id_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        rst = 1'b0;
        consume("after_late_ack");
        tick();
        tick();
        check("addr_queue_drained", exp_addr_q.size(), 32'd0);
        check("id_queue_drained", exp_id_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
